// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg
// Shared definitions for the register-bus master: default bus widths,
// the master FSM state type and the command record.
// No ports (package).
package reg_bus_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 4;

  // Master sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // One command as offered on the command interface, at default widths.
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/reg_bus_master_if.sv
// reg_bus_master_if
// Bundles the three channels around the register-bus master:
//   cmd_*  : valid/ready command channel (write flag, start addr, len, wdata)
//   bus_*  : register bus (re/we/addr/wdata out, combinational rdata back)
//   rsp_*  : valid/ready response channel (write flag, rdata, last)
// Modports: master = the bus master's view, slave = the view of everything
// around it (command source, register slaves, response sink).
interface reg_bus_master_if #(
  parameter int ADDR_W = reg_bus_pkg::DEF_ADDR_W,
  parameter int DATA_W = reg_bus_pkg::DEF_DATA_W,
  parameter int LEN_W  = reg_bus_pkg::DEF_LEN_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_wdata;

  logic              bus_re;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata,
    output cmd_ready,
    output bus_re, bus_we, bus_addr, bus_wdata,
    input  bus_rdata,
    output rsp_valid, rsp_write, rsp_rdata, rsp_last,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata,
    input  cmd_ready,
    input  bus_re, bus_we, bus_addr, bus_wdata,
    output bus_rdata,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_last,
    output rsp_ready
  );

endinterface

// File: rtl/reg_bus_addr_ctr.sv
// reg_bus_addr_ctr
// Current-address and beat counter for one burst.
// Ports:
//   clk, rst    clock, async active-high reset
//   load        start a new burst: take load_addr/load_len, clear beat
//   load_addr   burst start address
//   load_len    burst length minus one
//   incr        advance to the next beat (address wraps modulo 2^ADDR_W)
//   cur_addr    address of the current beat
//   last_beat   current beat is the final one of the burst
module reg_bus_addr_ctr #(
  parameter int ADDR_W = reg_bus_pkg::DEF_ADDR_W,
  parameter int LEN_W  = reg_bus_pkg::DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              incr,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last_beat
);

  logic [LEN_W-1:0] beat;
  logic [LEN_W-1:0] len_q;

  // Load takes priority; the address wraps naturally at its own width,
  // so a burst starting near the top of the map continues from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr <= '0;
      beat     <= '0;
      len_q    <= '0;
    end else if (load) begin
      cur_addr <= load_addr;
      beat     <= '0;
      len_q    <= load_len;
    end else if (incr) begin
      cur_addr <= cur_addr + ADDR_W'(1);
      beat     <= beat + LEN_W'(1);
    end
  end

  assign last_beat = (beat == len_q);

endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master
// Register-bus initiator. Takes read/write commands (single or incrementing
// burst, write data repeated to every beat), drives the register bus and
// returns one response per read beat or one per write command.
// Ports:
//   clk, rst  clock, async active-high reset
//   m         reg_bus_master_if.master: cmd_* in, bus_* out (rdata in),
//             rsp_* out (rsp_ready in)
// All bus_* outputs decode registered state only; no input reaches them
// combinationally.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W    = reg_bus_pkg::DEF_ADDR_W,
  parameter int DATA_W    = reg_bus_pkg::DEF_DATA_W,
  parameter int LEN_W     = reg_bus_pkg::DEF_LEN_W,
  parameter int READ_WAIT = 0
) (
  input logic              clk,
  input logic              rst,
  reg_bus_master_if.master m
);

  localparam logic [3:0] WAIT_MAX = 4'(READ_WAIT);

  state_e            state;
  state_e            next_state;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;
  logic              rsp_write_q;
  logic              rsp_last_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              load;
  logic              incr;
  logic              wait_clr;
  logic              wait_inc;
  logic              wr_done;
  logic              rd_capture;
  logic [ADDR_W-1:0] cur_addr;
  logic              last_beat;

  reg_bus_addr_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_addr (m.cmd_addr),
    .load_len  (m.cmd_len),
    .incr      (incr),
    .cur_addr  (cur_addr),
    .last_beat (last_beat)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes. A command is only looked at in IDLE;
  // writes stream one beat per cycle, reads hold bus_re for READ_WAIT+1
  // cycles and then park in RESP until the consumer takes the beat, which
  // leaves at least one idle bus cycle between read beats.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    incr       = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    wr_done    = 1'b0;
    rd_capture = 1'b0;
    case (state)
      IDLE: begin
        if (m.cmd_valid) begin
          load       = 1'b1;
          wait_clr   = 1'b1;
          next_state = m.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (last_beat) begin
          wr_done    = 1'b1;
          next_state = RESP;
        end else begin
          incr = 1'b1;
        end
      end
      READ: begin
        if (wait_cnt == WAIT_MAX) begin
          rd_capture = 1'b1;
          next_state = RESP;
        end else begin
          wait_inc = 1'b1;
        end
      end
      RESP: begin
        if (m.rsp_ready) begin
          if (rsp_last_q) begin
            next_state = IDLE;
          end else begin
            incr       = 1'b1;
            wait_clr   = 1'b1;
            next_state = READ;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latched write data, read wait counter and the response registers.
  // Response fields are only loaded on entry to RESP, so they stay stable
  // for as long as the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata_q     <= '0;
      wait_cnt    <= '0;
      rsp_write_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (load) begin
        wdata_q <= m.cmd_wdata;
      end
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (wr_done) begin
        rsp_write_q <= 1'b1;
        rsp_last_q  <= 1'b1;
        rsp_rdata_q <= '0;
      end else if (rd_capture) begin
        rsp_write_q <= 1'b0;
        rsp_last_q  <= last_beat;
        rsp_rdata_q <= m.bus_rdata;
      end
    end
  end

  // cmd_ready is also gated by rst so nothing is offered while reset is held.
  assign m.cmd_ready = (state == IDLE) && !rst;
  assign m.bus_we    = (state == WRITE);
  assign m.bus_re    = (state == READ);
  assign m.bus_addr  = ((state == WRITE) || (state == READ)) ? cur_addr : '0;
  assign m.bus_wdata = (state == WRITE) ? wdata_q : '0;
  assign m.rsp_valid = (state == RESP);
  assign m.rsp_write = rsp_write_q;
  assign m.rsp_last  = rsp_last_q;
  assign m.rsp_rdata = rsp_rdata_q;

endmodule
